maj_fold_ctrl: RTL and testbench

Folded (time-multiplexed) majority/threshold evaluator for the bias-decomposition majority family. It accepts one N-bit vector per transaction and sequences it through a single shared W-bit chunk popcount adder over ceil(N/W) cycles. It compares the accumulated count against a programmable bias threshold and returns the decision with valid/ready handshakes. It is the sequential, area-reduced counterpart of the flat N-input majority gate; its decision must equal (popcount(x) >= THRESH) for every input.

---
 rtl/maj_fold_ctrl.sv | 119 +++++++++++
 tb/tb_maj_fold_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_fold_ctrl.sv
// maj_fold_ctrl
// Folded majority/threshold evaluator. A single N-bit vector is accepted,
// then streamed through one shared W-bit popcount adder over
// NCHUNK = ceil(N/W) cycles. The accumulated count is compared against
// THRESH, and the decision is returned through a valid/ready handshake.
// With EARLY=1 the walk stops as soon as the outcome can no longer change.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (high only in IDLE)
//   in_x       N-bit vector to evaluate
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   out_y      decision: 1 iff count >= THRESH
//   out_count  accumulated ones count (partial count on early exit)
module maj_fold_ctrl #(
  parameter int N      = 35,
  parameter int W      = 5,
  parameter int THRESH = (N + 1) / 2,
  parameter int EARLY  = 0,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_y,
  output logic [CW-1:0] out_count
);

  localparam int NCHUNK = (N + W - 1) / W;
  // The shift register is padded to a whole number of chunks, so the
  // last chunk reads zeros beyond bit N-1.
  localparam int SW     = NCHUNK * W;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   shreg;
  logic [CW-1:0]   acc;
  logic [IW-1:0]   idx;

  logic [CW-1:0]   chunk_pop;
  logic [CW-1:0]   acc_new;
  int              consumed;
  int              rem;
  logic            last_chunk;
  logic            decided_hi;
  logic            decided_lo;
  logic            stop;

  // Shared chunk adder and exit decision. rem is the number of input bits
  // not yet counted after this add; if even all of them being ones cannot
  // reach THRESH, the outcome is already fixed at 0.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < W; i++) begin
      chunk_pop = chunk_pop + CW'(shreg[i]);
    end
    acc_new    = acc + chunk_pop;
    consumed   = W * (int'(idx) + 1);
    rem        = (consumed < N) ? (N - consumed) : 0;
    last_chunk = (int'(idx) == NCHUNK - 1);
    decided_hi = (int'(acc_new) >= THRESH);
    decided_lo = ((int'(acc_new) + rem) < THRESH);
    stop       = last_chunk || ((EARLY != 0) && (decided_hi || decided_lo));
  end

  // Control FSM with datapath. Reset wins over any handshake. The result
  // registers are only written on the exiting add, so they hold steady
  // throughout DONE while the consumer applies backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_y     <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= SW'(in_x);
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc   <= acc_new;
          shreg <= shreg >> W;
          idx   <= idx + 1'b1;
          if (stop) begin
            out_y     <= decided_hi;
            out_count <= acc_new;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// tb_maj_fold_ctrl
// Self-checking bench for maj_fold_ctrl. The main instance (N=35, W=5,
// THRESH=18, EARLY=0) runs a table of vectors, random vectors, a
// backpressure/back-to-back sequence and a mid-transaction reset, using a
// scoreboard queue. A generate loop then sweeps further configurations
// against a chunk-walking reference model.
module tb_maj_fold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic        out_y;
  logic [5:0]  out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc;
  int hs_cyc;
  int sweep_done = 0;
  bit start_sweep = 1'b0;

  typedef struct packed {
    logic       y;
    logic [5:0] cnt;
  } exp_t;

  typedef struct {
    logic [34:0] x;
    logic        y;
    logic [5:0]  cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  // Free-running clock and cycle counter used for latency measurement
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  maj_fold_ctrl #(.N(35), .W(5), .THRESH(18), .EARLY(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_count(out_count)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Offer one vector at the first negedge where in_ready is high and push
  // its expected result onto the scoreboard.
  task automatic applyStimulus(input logic [34:0] x, input logic ey, input logic [5:0] ec);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeoutFail("in_ready_wait");
    in_x     = x;
    in_valid = 1'b1;
    sb.push_back('{y: ey, cnt: ec});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_x       = '1;
  endtask

  // Wait for the result, compare against the scoreboard, optionally hold
  // off out_ready for some cycles, then complete the handshake.
  task automatic collectResult(input int exp_lat, input int hold);
    int   t = 0;
    int   busy_ready = 0;
    int   unstable = 0;
    exp_t e;
    logic       y0;
    logic [5:0] c0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      if (in_ready) busy_ready = 1;
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      timeoutFail("out_valid_wait");
      return;
    end
    if (in_ready) busy_ready = 1;
    checkOutput("latency", cyc - accept_cyc, exp_lat);
    checkOutput("in_ready_busy", busy_ready, 0);
    if (sb.size() == 0) begin
      timeoutFail("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checkOutput("out_y", int'(out_y), int'(e.y));
    checkOutput("out_count", int'(out_count), int'(e.cnt));
    y0 = out_y;
    c0 = out_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid || out_y !== y0 || out_count !== c0 || in_ready) unstable++;
    end
    if (hold > 0) checkOutput("backpressure_stable", unstable, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc    = cyc;
    out_ready = 1'b0;
  endtask

  // Main directed sequence on the primary instance
  initial begin
    logic [34:0] x;
    int dens;
    int c;
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;

    tbl[0] = '{x: 35'h0_0000_0000, y: 1'b0, cnt: 6'd0};
    tbl[1] = '{x: 35'h0_0003_FFFF, y: 1'b1, cnt: 6'd18};
    tbl[2] = '{x: 35'h0_0001_FFFF, y: 1'b0, cnt: 6'd17};
    tbl[3] = '{x: 35'h7_FFFF_FFFF, y: 1'b1, cnt: 6'd35};
    tbl[4] = '{x: 35'h5_5555_5555, y: 1'b1, cnt: 6'd18};
    tbl[5] = '{x: 35'h4_0000_0001, y: 1'b0, cnt: 6'd2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_y", int'(out_y), 0);
    checkOutput("reset_out_count", int'(out_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].x, tbl[i].y, tbl[i].cnt);
      collectResult(7, 0);
    end

    for (int i = 0; i < 6; i++) begin
      dens = $urandom_range(30, 70);
      for (int b = 0; b < 35; b++) x[b] = ($urandom_range(0, 99) < dens);
      c = $countones(x);
      applyStimulus(x, (c >= 18), 6'(c));
      collectResult(7, 0);
    end

    // Backpressure for 5 cycles, then a back-to-back second vector
    applyStimulus(35'h0_0003_FFFF, 1'b1, 6'd18);
    collectResult(7, 5);
    applyStimulus(35'h0_0001_FFFF, 1'b0, 6'd17);
    checkOutput("b2b_accept_gap", accept_cyc - hs_cyc, 1);
    collectResult(7, 0);

    // Reset during the third ACCUM cycle aborts the transaction
    applyStimulus(35'h7_FFFF_FFFF, 1'b1, 6'd35);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    sb.delete();
    applyStimulus(35'h0_0003_FFFF, 1'b1, 6'd18);
    collectResult(7, 0);

    start_sweep = 1'b1;
    t = 0;
    while (sweep_done < 8 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (sweep_done < 8) timeoutFail("sweep_complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Configuration sweep: each block owns one instance and checks it against
  // a reference that walks the chunks and applies the early-exit rule.
  for (genvar g = 0; g < 8; g++) begin : g_sweep
    localparam int GN = (g == 4 || g == 7) ? 7 : 35;
    localparam int GW = (g == 0) ? 1 : (g == 2) ? 7 : (g == 3) ? 35 :
                        (g == 4 || g == 7) ? 3 : 5;
    localparam int GT = (g == 4 || g == 7) ? 4 : (g == 5) ? 0 : (g == 6) ? 36 : 18;
    localparam int GE = (g == 1 || g == 5 || g == 7) ? 1 : 0;
    localparam int GCW = $clog2(GN + 1);
    localparam int GNC = (GN + GW - 1) / GW;

    logic           s_in_valid;
    logic           s_in_ready;
    logic [GN-1:0]  s_in_x;
    logic           s_out_valid;
    logic           s_out_ready;
    logic           s_out_y;
    logic [GCW-1:0] s_out_count;

    maj_fold_ctrl #(.N(GN), .W(GW), .THRESH(GT), .EARLY(GE)) u_sw (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_x(s_in_x),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_y(s_out_y), .out_count(s_out_count)
    );

    initial begin
      logic [GN-1:0] x;
      int dens, cnt, rem, lat, acc_c, t, hi;
      bit stopped;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      s_in_x      = '0;
      while (!start_sweep) @(posedge clk);

      for (int v = 0; v < 12; v++) begin
        if (v == 0) x = '1;
        else if (v == 1) x = '0;
        else begin
          dens = $urandom_range(20, 80);
          for (int b = 0; b < GN; b++) x[b] = ($urandom_range(0, 99) < dens);
        end

        cnt = 0;
        lat = GNC;
        stopped = 1'b0;
        for (int c = 0; c < GNC; c++) begin
          if (!stopped) begin
            for (int b = c * GW; b < (c + 1) * GW && b < GN; b++) cnt += int'(x[b]);
            rem = GN - GW * (c + 1);
            if (rem < 0) rem = 0;
            if (GE != 0 && (cnt >= GT || cnt + rem < GT)) begin
              stopped = 1'b1;
              lat = c + 1;
            end
          end
        end
        if (GE == 0) cnt = $countones(x);

        @(negedge clk);
        t = 0;
        while (!s_in_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!s_in_ready) timeoutFail($sformatf("cfg%0d_in_ready_wait", g));
        s_in_x     = x;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_c      = cyc;
        s_in_valid = 1'b0;

        @(negedge clk);
        t = 0;
        while (!s_out_valid && t < 60) begin
          @(negedge clk);
          t++;
        end
        if (!s_out_valid) begin
          timeoutFail($sformatf("cfg%0d_out_valid_wait", g));
        end else begin
          hi = ($countones(x) >= GT) ? 1 : 0;
          checkOutput($sformatf("cfg%0d_v%0d_y", g, v), int'(s_out_y), hi);
          checkOutput($sformatf("cfg%0d_v%0d_count", g, v), int'(s_out_count), cnt);
          checkOutput($sformatf("cfg%0d_v%0d_latency", g, v), cyc - acc_c, lat);
          s_out_ready = 1'b1;
          @(posedge clk);
          #1 s_out_ready = 1'b0;
        end
      end
      sweep_done++;
    end
  end

endmodule
